// File: rtl/integer_divider_pkg.sv
// ============================================================================
//  Module   : integer_divider_pkg
//  Brief    : Shared state encoding and sizing constants for integer_divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package integer_divider_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        ITER = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int c_default_width = 4;
    localparam int c_cnt_width     = $clog2(c_default_width + 1);

endpackage

`default_nettype wire

// File: rtl/integer_divider_step.sv
// ============================================================================
//  Module   : divider_step
//  Brief    : One restoring shift-subtract iteration on the {R,Q} pair.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module divider_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // R < D always holds, so the shifted remainder stays below 2*D and the
    // top bit of the WIDTH+1 bit difference is a valid sign.
    assign w_shift = {i_r, i_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_d};

    assign o_r = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_q = {i_q[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/integer_divider.sv
// ============================================================================
//  Module   : integer_divider
//  Brief    : Multi-cycle unsigned restoring divider, one quotient bit/clock.
//             Optional macro DIV_STICKY_ERR_EN holds Err until next accepted Go.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module integer_divider
    import integer_divider_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Go,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Done,
    output logic             Err,
    output logic [2:0]       CS,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int c_cnt_w = (WIDTH == c_default_width) ? c_cnt_width
                                                        : $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_done;
    logic               r_err;
    logic [WIDTH-1:0]   w_step_q;
    logic [WIDTH-1:0]   w_step_r;
    logic               w_div_zero;
    logic               w_last;

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_step_r),
        .o_q (w_step_q)
    );

    assign w_div_zero = (Divisor == '0);
    assign w_last     = (r_cnt == c_cnt_w'(1));

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: begin
                if (Go) begin
                    w_next_state = w_div_zero ? ERR : INIT;
                end
            end
            INIT:    w_next_state = ITER;
            ITER:    w_next_state = w_last ? DONE : ITER;
            DONE:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == DONE) || (w_next_state == ERR);
`ifdef DIV_STICKY_ERR_EN
            if (w_next_state == ERR) begin
                r_err <= 1'b1;
            end else if (r_state == IDLE && Go) begin
                r_err <= 1'b0;
            end
`else
            r_err   <= (w_next_state == ERR);
`endif
            case (r_state)
                IDLE: begin
                    if (Go) begin
                        if (w_div_zero) begin
                            r_quot <= '0;
                            r_rem  <= '0;
                        end else begin
                            r_q <= Dividend;
                            r_d <= Divisor;
                            r_r <= '0;
                        end
                    end
                end
                INIT: r_cnt <= c_cnt_w'(WIDTH);
                ITER: begin
                    r_q   <= w_step_q;
                    r_r   <= w_step_r;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    // Publish the result on the final iteration only.
                    if (w_last) begin
                        r_quot <= w_step_q;
                        r_rem  <= w_step_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Done      = r_done;
    assign Err       = r_err;
    assign CS        = r_state;
    assign Quotient  = r_quot;
    assign Remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_integer_divider.sv
// ============================================================================
//  Module   : tb_integer_divider
//  Brief    : Directed self-checking bench for integer_divider (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_integer_divider;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Go = 1'b0;
    logic [3:0] Dividend = 4'd0;
    logic [3:0] Divisor = 4'd0;
    logic       Done;
    logic       Err;
    logic [2:0] CS;
    logic [3:0] Quotient;
    logic [3:0] Remainder;

    int n_checks = 0;
    int n_pass   = 0;

    integer_divider #(.WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Go        (Go),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Done      (Done),
        .Err       (Err),
        .CS        (CS),
        .Quotient  (Quotient),
        .Remainder (Remainder)
    );

    always #5 CLK = ~CLK;

    // Waits (at negedges) for Done, bounded by max_cycles.
    task automatic wait_done(input int max_cycles, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < max_cycles) begin
            @(negedge CLK);
            Go  = 1'b0;
            lat = lat + 1;
            if (Done) seen = 1'b1;
        end
    endtask

    task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat, output bit seen);
        @(negedge CLK);
        Dividend = a;
        Divisor  = b;
        Go       = 1'b1;
        wait_done(20, lat, seen);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        Go  = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (CS !== 3'd0) $display("FAIL reset_cs: got %0d expected 0", CS); else n_pass++;
        n_checks++; if (Done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", Done); else n_pass++;
        n_checks++; if (Err !== 1'b0) $display("FAIL reset_err: got %0b expected 0", Err); else n_pass++;
        n_checks++; if (Quotient !== 4'd0) $display("FAIL reset_q: got %0d expected 0", Quotient); else n_pass++;
        n_checks++; if (Remainder !== 4'd0) $display("FAIL reset_r: got %0d expected 0", Remainder); else n_pass++;
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic;
        logic [2:0] exp_cs [0:7];
        exp_cs = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
        @(negedge CLK);
        Dividend = 4'd13;
        Divisor  = 4'd4;
        Go       = 1'b1;
        n_checks++; if (CS !== exp_cs[0]) $display("FAIL basic_cs0: got %0d expected %0d", CS, exp_cs[0]); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            Go = 1'b0;
            n_checks++;
            if (CS !== exp_cs[k]) $display("FAIL basic_cs%0d: got %0d expected %0d", k, CS, exp_cs[k]); else n_pass++;
            n_checks++;
            if (Done !== (k == 6)) $display("FAIL basic_done%0d: got %0b expected %0b", k, Done, (k == 6)); else n_pass++;
        end
        n_checks++; if (Quotient !== 4'd3) $display("FAIL basic_q: got %0d expected 3", Quotient); else n_pass++;
        n_checks++; if (Remainder !== 4'd1) $display("FAIL basic_r: got %0d expected 1", Remainder); else n_pass++;
        n_checks++; if (Err !== 1'b0) $display("FAIL basic_err: got %0b expected 0", Err); else n_pass++;
    endtask

    task automatic test_vectors;
        logic [3:0] va [0:3];
        logic [3:0] vb [0:3];
        logic [3:0] vq [0:3];
        logic [3:0] vr [0:3];
        int  lat;
        bit  seen;
        va = '{4'd15, 4'd15, 4'd3, 4'd0};
        vb = '{4'd1,  4'd15, 4'd7, 4'd5};
        vq = '{4'd15, 4'd1,  4'd0, 4'd0};
        vr = '{4'd0,  4'd0,  4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, seen);
            n_checks++;
            if (!seen || lat != 6) $display("FAIL vec%0d_latency: got %0d (seen %0b) expected 6", i, lat, seen); else n_pass++;
            n_checks++;
            if (Quotient !== vq[i]) $display("FAIL vec%0d_q %0d/%0d: got %0d expected %0d", i, va[i], vb[i], Quotient, vq[i]); else n_pass++;
            n_checks++;
            if (Remainder !== vr[i]) $display("FAIL vec%0d_r %0d/%0d: got %0d expected %0d", i, va[i], vb[i], Remainder, vr[i]); else n_pass++;
        end
    endtask

    task automatic test_div_zero;
        int lat;
        bit seen;
        bit exp_sticky;
`ifdef DIV_STICKY_ERR_EN
        exp_sticky = 1'b1;
`else
        exp_sticky = 1'b0;
`endif
        run_div(4'd15, 4'd1, lat, seen);
        repeat (2) @(negedge CLK);
        n_checks++; if (Quotient !== 4'd15) $display("FAIL hold_q: got %0d expected 15", Quotient); else n_pass++;
        Dividend = 4'd9;
        Divisor  = 4'd0;
        Go       = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        n_checks++; if (CS !== 3'd4) $display("FAIL dz_cs: got %0d expected 4", CS); else n_pass++;
        n_checks++; if (Done !== 1'b1) $display("FAIL dz_done: got %0b expected 1", Done); else n_pass++;
        n_checks++; if (Err !== 1'b1) $display("FAIL dz_err: got %0b expected 1", Err); else n_pass++;
        n_checks++; if (Quotient !== 4'd0) $display("FAIL dz_q: got %0d expected 0", Quotient); else n_pass++;
        n_checks++; if (Remainder !== 4'd0) $display("FAIL dz_r: got %0d expected 0", Remainder); else n_pass++;
        @(negedge CLK);
        n_checks++; if (CS !== 3'd0) $display("FAIL dz_cs_after: got %0d expected 0", CS); else n_pass++;
        n_checks++; if (Done !== 1'b0) $display("FAIL dz_done_after: got %0b expected 0", Done); else n_pass++;
        n_checks++; if (Err !== exp_sticky) $display("FAIL dz_err_after: got %0b expected %0b", Err, exp_sticky); else n_pass++;
        @(negedge CLK);
        n_checks++; if (Err !== exp_sticky) $display("FAIL dz_err_hold: got %0b expected %0b", Err, exp_sticky); else n_pass++;
        Dividend = 4'd6;
        Divisor  = 4'd2;
        Go       = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        n_checks++; if (Err !== 1'b0) $display("FAIL dz_err_clear: got %0b expected 0", Err); else n_pass++;
        wait_done(20, lat, seen);
        n_checks++; if (!seen || Quotient !== 4'd3 || Remainder !== 4'd0)
            $display("FAIL dz_recover: got q=%0d r=%0d seen=%0b expected q=3 r=0", Quotient, Remainder, seen); else n_pass++;
    endtask

    task automatic test_go_during_iter;
        int n_done = 0;
        @(negedge CLK);
        Dividend = 4'd13;
        Divisor  = 4'd4;
        Go       = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        @(negedge CLK);
        Dividend = 4'd8;
        Divisor  = 4'd2;
        Go       = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (Done) n_done++;
            @(negedge CLK);
        end
        n_checks++; if (n_done != 1) $display("FAIL ignore_go_done_count: got %0d expected 1", n_done); else n_pass++;
        n_checks++; if (Quotient !== 4'd3) $display("FAIL ignore_go_q: got %0d expected 3", Quotient); else n_pass++;
        n_checks++; if (Remainder !== 4'd1) $display("FAIL ignore_go_r: got %0d expected 1", Remainder); else n_pass++;
    endtask

    task automatic test_operand_change;
        int lat;
        bit seen;
        @(negedge CLK);
        Dividend = 4'd14;
        Divisor  = 4'd3;
        Go       = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        @(negedge CLK);
        Dividend = 4'd1;
        Divisor  = 4'd1;
        wait_done(20, lat, seen);
        n_checks++; if (!seen) $display("FAIL opchg_timeout: got no Done expected Done"); else n_pass++;
        n_checks++; if (Quotient !== 4'd4) $display("FAIL opchg_q: got %0d expected 4", Quotient); else n_pass++;
        n_checks++; if (Remainder !== 4'd2) $display("FAIL opchg_r: got %0d expected 2", Remainder); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        int n_done = 0;
        @(negedge CLK);
        Dividend = 4'd13;
        Divisor  = 4'd4;
        Go       = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_checks++; if (CS !== 3'd0) $display("FAIL rstmid_cs: got %0d expected 0", CS); else n_pass++;
        n_checks++; if (Quotient !== 4'd0) $display("FAIL rstmid_q: got %0d expected 0", Quotient); else n_pass++;
        n_checks++; if (Remainder !== 4'd0) $display("FAIL rstmid_r: got %0d expected 0", Remainder); else n_pass++;
        n_checks++; if (Done !== 1'b0) $display("FAIL rstmid_done: got %0b expected 0", Done); else n_pass++;
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (Done) n_done++;
        end
        n_checks++; if (n_done != 0) $display("FAIL rstmid_no_done: got %0d expected 0", n_done); else n_pass++;
        run_div(4'd10, 4'd3, lat, seen);
        n_checks++; if (!seen || Quotient !== 4'd3 || Remainder !== 4'd1)
            $display("FAIL rstmid_fresh: got q=%0d r=%0d seen=%0b expected q=3 r=1", Quotient, Remainder, seen); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n_done = 0;
        @(negedge CLK);
        Dividend = 4'd6;
        Divisor  = 4'd3;
        Go       = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (Done) n_done++;
        end
        Go = 1'b0;
        repeat (9) @(negedge CLK);
        n_checks++; if (n_done != 2) $display("FAIL b2b_done_count: got %0d expected 2", n_done); else n_pass++;
        n_checks++; if (Quotient !== 4'd2 || Remainder !== 4'd0)
            $display("FAIL b2b_result: got q=%0d r=%0d expected q=2 r=0", Quotient, Remainder); else n_pass++;
        n_checks++; if (CS !== 3'd0) $display("FAIL b2b_idle: got %0d expected 0", CS); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_div_zero;
        test_go_during_iter;
        test_operand_change;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
